i2c_apb_arbiter: RTL and testbench
==================================

I2C_APB_ARBITER -- requirements
Module: i2c_apb_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 16, ACCESS-phase cycles without pready before abort; legal range 2..255.
REQ-002 apb_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 preset  in  1  reset, synchronous, active-high.
REQ-004 reqN_valid  in  1  (N=0,1) requester N has a pending transfer.
REQ-005 reqN_write  in  1  1=write, 0=read.
REQ-006 reqN_addr  in  8  target register address.
REQ-007 reqN_wdata  in  8  write data.
REQ-008 reqN_ready  out  1  one-cycle completion pulse to requester N.
REQ-009 reqN_rdata  out  8  read data, valid while reqN_ready=1.
REQ-010 reqN_err  out  1  timeout flag, valid while reqN_ready=1.
REQ-011 paddr  out  8  APB address to I2C master.
REQ-012 pwrite  out  1  APB direction.
REQ-013 psel  out  1  APB select.
REQ-014 penable  out  1  APB enable.
REQ-015 pwdata  out  8  APB write data.
REQ-016 prdata  in  8  APB read data.
REQ-017 pready  in  1  APB slave ready.

Function
REQ-018 FSM states IDLE, SETUP, ACCESS, DONE; every output decoded from registers only, no combinational input-to-output path.
REQ-019 IDLE: no valid -> stay; any valid -> grant, latch granted requester's addr/write/wdata, go SETUP.
REQ-020 Arbitration: one valid -> grant it; both valid -> grant requester != last_grant; last_grant updated on every grant.
REQ-021 SETUP: psel=1, penable=0 for exactly one cycle, then ACCESS.
REQ-022 ACCESS: psel=1, penable=1; pready=1 -> capture prdata (reads) or 0 (writes) into rdata, err=0, go DONE.
REQ-023 ACCESS wait counter, 8 bit, cleared on SETUP entry, +1 per ACCESS cycle with pready=0.
REQ-024 Counter == TIMEOUT-1 with pready=0 -> rdata=0, err=1, go DONE; pready=1 in that same cycle -> normal success, err=0.
REQ-025 DONE: granted requester's ready=1 for exactly one cycle with rdata/err; other requester's ready=0; psel=penable=0; next state IDLE; valid not sampled in DONE.
REQ-026 paddr/pwrite = latched values during SETUP/ACCESS; pwdata = latched wdata when write, 0 when read; all hold last value elsewhere.
REQ-027 Requester holds valid and fields stable from assertion until its ready pulse; arbiter ignores field changes after grant.
REQ-028 Minimum 4 cycles per transfer (IDLE->SETUP->ACCESS->DONE); back-to-back grant no earlier than IDLE cycle following DONE.
REQ-029 reqN_rdata/reqN_err hold value outside ready pulse; only meaningful with ready=1.

Reset
REQ-030 preset=1 at a clock edge -> state IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, all ready/err=0, all rdata=0, counter=0, last_grant=1 (req0 wins first tie).
REQ-031 Reset mid-transfer (SETUP/ACCESS/DONE) -> abort, no ready pulse issued, psel/penable low the cycle after the reset edge.

Verification
REQ-032 req0 write addr=0x02 wdata=0xA5, pready=1 first ACCESS cycle -> psel 2 cycles, penable 1 cycle, paddr=0x02, pwdata=0xA5, req0_ready pulse 3 cycles after grant, err=0.
REQ-033 req1 read addr=0x04, pready low 3 ACCESS cycles then high with prdata=0x3C -> req1_rdata=0x3C, err=0, req0_ready stays 0.
REQ-034 Both valid continuously after reset, 4 transfers -> grant order req0, req1, req0, req1.
REQ-035 TIMEOUT=16, pready held 0 -> after 16 ACCESS cycles ready pulse with err=1, rdata=0, psel drops; pready=1 exactly on 16th cycle -> err=0.
REQ-036 preset asserted during ACCESS -> no ready pulse, all outputs at reset values next cycle, next tie grants req0.

Source files
------------

// File: rtl/i2c_apb_arbiter.sv
// i2c_apb_arbiter
//   Arbitrates two requesters onto one APB master port that drives an I2C
//   controller's register file. Transfers run through IDLE -> SETUP ->
//   ACCESS -> DONE. Ties alternate between the requesters, with requester 0
//   winning the first tie after reset. An ACCESS phase that sees no pready
//   for TIMEOUT cycles is aborted and returned with err=1.
//
// Ports
//   apb_clk, preset             clock, synchronous active-high reset
//   reqN_valid/write/addr/wdata requester N transfer request (N = 0, 1)
//   reqN_ready/rdata/err        requester N completion pulse and result
//   paddr/pwrite/psel/penable/pwdata, prdata/pready   APB master port
//
// All outputs come straight from flops or from a decode of the state
// register, so no input reaches an output combinationally.
module i2c_apb_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       apb_clk,
    input  logic       preset,
    input  logic       req0_valid,
    input  logic       req0_write,
    input  logic [7:0] req0_addr,
    input  logic [7:0] req0_wdata,
    output logic       req0_ready,
    output logic [7:0] req0_rdata,
    output logic       req0_err,
    input  logic       req1_valid,
    input  logic       req1_write,
    input  logic [7:0] req1_addr,
    input  logic [7:0] req1_wdata,
    output logic       req1_ready,
    output logic [7:0] req1_rdata,
    output logic       req1_err,
    output logic [7:0] paddr,
    output logic       pwrite,
    output logic       psel,
    output logic       penable,
    output logic [7:0] pwdata,
    input  logic [7:0] prdata,
    input  logic       pready
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       grant_q, grant_d;           // 0 = req0, 1 = req1
    logic       last_grant_q, last_grant_d;
    logic [7:0] addr_q, addr_d;
    logic       write_q, write_d;
    logic [7:0] pwdata_q, pwdata_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] rdata0_q, rdata0_d;
    logic [7:0] rdata1_q, rdata1_d;
    logic       err0_q, err0_d;
    logic       err1_q, err1_d;

    logic       sel;
    logic       res_we;
    logic       res_err;
    logic [7:0] res_data;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        write_d      = write_q;
        pwdata_d     = pwdata_q;
        cnt_d        = cnt_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        err0_d       = err0_q;
        err1_d       = err1_q;
        sel          = 1'b0;
        res_we       = 1'b0;
        res_err      = 1'b0;
        res_data     = '0;

        unique case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    // On a tie the requester not granted last time wins.
                    sel          = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
                    grant_d      = sel;
                    last_grant_d = sel;
                    addr_d       = sel ? req1_addr  : req0_addr;
                    write_d      = sel ? req1_write : req0_write;
                    if (sel ? req1_write : req0_write) begin
                        pwdata_d = sel ? req1_wdata : req0_wdata;
                    end else begin
                        pwdata_d = '0;
                    end
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    res_we   = 1'b1;
                    res_data = write_q ? 8'h00 : prdata;
                    state_d  = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    res_we  = 1'b1;
                    res_err = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase

        if (res_we) begin
            if (grant_q) begin
                rdata1_d = res_data;
                err1_d   = res_err;
            end else begin
                rdata0_d = res_data;
                err0_d   = res_err;
            end
        end
    end

    always_ff @(posedge apb_clk) begin
        if (preset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            write_q      <= 1'b0;
            pwdata_q     <= '0;
            cnt_q        <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            pwdata_q     <= pwdata_d;
            cnt_q        <= cnt_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
        end
    end

    assign psel       = (state_q == SETUP) || (state_q == ACCESS);
    assign penable    = (state_q == ACCESS);
    assign paddr      = addr_q;
    assign pwrite     = write_q;
    assign pwdata     = pwdata_q;
    assign req0_ready = (state_q == DONE) && !grant_q;
    assign req1_ready = (state_q == DONE) &&  grant_q;
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;
    assign req0_err   = err0_q;
    assign req1_err   = err1_q;

endmodule

// File: tb/tb_i2c_apb_arbiter.sv
// tb_i2c_apb_arbiter
//   Self-checking bench for i2c_apb_arbiter: directed scenarios plus a
//   randomized two-requester run checked against a transaction-level model.
module tb_i2c_apb_arbiter;

    localparam int unsigned TO = 16;

    logic       apb_clk = 1'b0;
    logic       preset = 1'b1;
    logic       req0_valid = 1'b0, req0_write = 1'b0;
    logic [7:0] req0_addr = '0, req0_wdata = '0;
    logic       req1_valid = 1'b0, req1_write = 1'b0;
    logic [7:0] req1_addr = '0, req1_wdata = '0;
    logic       req0_ready, req0_err, req1_ready, req1_err;
    logic [7:0] req0_rdata, req1_rdata;
    logic [7:0] paddr, pwdata;
    logic       pwrite, psel, penable;
    logic [7:0] prdata = '0;
    logic       pready = 1'b0;

    i2c_apb_arbiter #(.TIMEOUT(TO)) dut (
        .apb_clk(apb_clk), .preset(preset),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rdata(req0_rdata),
        .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rdata(req1_rdata),
        .req1_err(req1_err),
        .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
        .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    always #5 apb_clk = ~apb_clk;

    typedef struct {
        int         id;
        logic [7:0] rdata;
        logic       err;
        int         cyc;
    } done_t;

    typedef struct {
        int         wait_n;
        logic [7:0] rd;
        int         setup_cyc;
        logic [7:0] addr;
        logic       wr;
        logic [7:0] wd;
        logic       v0;
        logic       v1;
    } grant_t;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wd;
    } tx_t;

    done_t  done_q[$];
    grant_t slog[$];
    tx_t    iss0[$];
    tx_t    iss1[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int psel_cnt = 0, pen_cnt = 0, rdy0_cnt = 0, rdy1_cnt = 0;

    bit         slave_random = 1'b0;
    int         slave_wait   = 0;
    logic [7:0] slave_rd     = '0;
    logic       v0_edge = 1'b0, v1_edge = 1'b0;

    // Valid levels seen by the arbiter at each rising edge.
    initial forever begin
        @(posedge apb_clk);
        v0_edge = req0_valid;
        v1_edge = req1_valid;
    end

    // Bus monitor and APB slave: logs every grant (SETUP cycle) and every
    // completion pulse, and answers ACCESS cycles after a chosen wait.
    initial begin : mon
        grant_t     g;
        done_t      d;
        int         acc_n;
        int         cur_wait;
        logic [7:0] cur_rd;
        acc_n = 0; cur_wait = 0; cur_rd = '0;
        forever begin
            @(negedge apb_clk);
            cyc++;
            if (psel)    psel_cnt++;
            if (penable) pen_cnt++;
            if (req0_ready) begin
                rdy0_cnt++;
                d.id = 0; d.rdata = req0_rdata; d.err = req0_err; d.cyc = cyc;
                done_q.push_back(d);
            end
            if (req1_ready) begin
                rdy1_cnt++;
                d.id = 1; d.rdata = req1_rdata; d.err = req1_err; d.cyc = cyc;
                done_q.push_back(d);
            end
            if (psel && !penable) begin
                g.wait_n    = slave_random ? int'($urandom_range(0, TO + 2)) : slave_wait;
                g.rd        = slave_random ? 8'($urandom_range(0, 255)) : slave_rd;
                g.setup_cyc = cyc;
                g.addr      = paddr;
                g.wr        = pwrite;
                g.wd        = pwdata;
                g.v0        = v0_edge;
                g.v1        = v1_edge;
                slog.push_back(g);
                cur_wait = g.wait_n;
                cur_rd   = g.rd;
                acc_n    = 0;
                pready   = 1'b0;
                prdata   = 8'hEE;
            end else if (psel && penable) begin
                pready = (acc_n == cur_wait);
                prdata = pready ? cur_rd : 8'hEE;
                acc_n++;
            end else begin
                pready = 1'b0;
                prdata = 8'hEE;
                acc_n  = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge apb_clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        done_q.delete();
        slog.delete();
        iss0.delete();
        iss1.delete();
        psel_cnt = 0; pen_cnt = 0; rdy0_cnt = 0; rdy1_cnt = 0;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        preset     = 1'b1;
        step(2);
        preset = 1'b0;
        clear_logs();
    endtask

    task automatic wait_done(input int n, input int budget);
        int k;
        k = 0;
        while (done_q.size() < n && k < budget) begin
            step(1);
            k++;
        end
    endtask

    task automatic test_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        preset     = 1'b1;
        step(2);
        n_checks++;
        if ({psel, penable, pwrite, paddr, pwdata} !== 19'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h, required 0", {psel, penable, pwrite, paddr, pwdata});
        end
        n_checks++;
        if ({req0_ready, req0_err, req0_rdata} !== 10'h0) begin
            n_fail++;
            $display("FAIL reset_req0: got %h, required 0", {req0_ready, req0_err, req0_rdata});
        end
        n_checks++;
        if ({req1_ready, req1_err, req1_rdata} !== 10'h0) begin
            n_fail++;
            $display("FAIL reset_req1: got %h, required 0", {req1_ready, req1_err, req1_rdata});
        end
        preset = 1'b0;
        clear_logs();
    endtask

    task automatic test_single_write();
        int issue;
        clear_logs();
        slave_random = 1'b0;
        slave_wait   = 0;
        req0_write = 1'b1; req0_addr = 8'h02; req0_wdata = 8'hA5; req0_valid = 1'b1;
        issue = cyc;
        wait_done(1, 40);
        req0_valid = 1'b0;
        n_checks++;
        if (done_q.size() !== 1 || slog.size() !== 1) begin
            n_fail++;
            $display("FAIL write_complete: got %0d completions, required 1", done_q.size());
            return;
        end
        n_checks++;
        if (done_q[0].id !== 0 || done_q[0].cyc !== issue + 3) begin
            n_fail++;
            $display("FAIL write_pulse: got id %0d at +%0d, required id 0 at +3",
                     done_q[0].id, done_q[0].cyc - issue);
        end
        n_checks++;
        if (done_q[0].err !== 1'b0 || done_q[0].rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL write_result: got err %b rdata %h, required err 0 rdata 00",
                     done_q[0].err, done_q[0].rdata);
        end
        n_checks++;
        if (psel_cnt !== 2 || pen_cnt !== 1) begin
            n_fail++;
            $display("FAIL write_phases: got psel %0d penable %0d cycles, required 2 and 1",
                     psel_cnt, pen_cnt);
        end
        n_checks++;
        if (slog[0].addr !== 8'h02 || slog[0].wd !== 8'hA5 || slog[0].wr !== 1'b1) begin
            n_fail++;
            $display("FAIL write_bus: got addr %h wdata %h write %b, required 02 A5 1",
                     slog[0].addr, slog[0].wd, slog[0].wr);
        end
        step(3);
        n_checks++;
        if (rdy0_cnt !== 1 || rdy1_cnt !== 0) begin
            n_fail++;
            $display("FAIL write_single_pulse: got ready0 %0d ready1 %0d, required 1 and 0",
                     rdy0_cnt, rdy1_cnt);
        end
    endtask

    task automatic test_read_wait();
        int issue;
        clear_logs();
        slave_wait = 3;
        slave_rd   = 8'h3C;
        req1_write = 1'b0; req1_addr = 8'h04; req1_wdata = 8'hFF; req1_valid = 1'b1;
        issue = cyc;
        wait_done(1, 40);
        req1_valid = 1'b0;
        n_checks++;
        if (done_q.size() !== 1 || slog.size() !== 1) begin
            n_fail++;
            $display("FAIL read_complete: got %0d completions, required 1", done_q.size());
            return;
        end
        n_checks++;
        if (done_q[0].id !== 1 || done_q[0].cyc !== issue + 6) begin
            n_fail++;
            $display("FAIL read_pulse: got id %0d at +%0d, required id 1 at +6",
                     done_q[0].id, done_q[0].cyc - issue);
        end
        n_checks++;
        if (done_q[0].rdata !== 8'h3C || done_q[0].err !== 1'b0) begin
            n_fail++;
            $display("FAIL read_result: got rdata %h err %b, required 3C 0",
                     done_q[0].rdata, done_q[0].err);
        end
        n_checks++;
        if (slog[0].addr !== 8'h04 || slog[0].wr !== 1'b0 || slog[0].wd !== 8'h00 || pen_cnt !== 4) begin
            n_fail++;
            $display("FAIL read_bus: got addr %h write %b wdata %h access %0d, required 04 0 00 4",
                     slog[0].addr, slog[0].wr, slog[0].wd, pen_cnt);
        end
        step(3);
        n_checks++;
        if (rdy0_cnt !== 0 || req1_rdata !== 8'h3C || req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL read_hold: got ready0 %0d rdata1 %h ready1 %b, required 0 3C 0",
                     rdy0_cnt, req1_rdata, req1_ready);
        end
    endtask

    task automatic test_back_to_back();
        int exp_id;
        do_reset();
        slave_wait = 0;
        req0_write = 1'b0; req0_addr = 8'h11;
        req1_write = 1'b0; req1_addr = 8'h22;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        wait_done(4, 100);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n_checks++;
        if (done_q.size() !== 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d completions, required 4", done_q.size());
            return;
        end
        for (int i = 0; i < 4; i++) begin
            exp_id = i % 2;
            n_checks++;
            if (done_q[i].id !== exp_id) begin
                n_fail++;
                $display("FAIL b2b_order[%0d]: got req%0d, required req%0d", i, done_q[i].id, exp_id);
            end
        end
        for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (done_q[i].cyc - done_q[i-1].cyc !== 4) begin
                n_fail++;
                $display("FAIL b2b_spacing[%0d]: got %0d cycles, required 4",
                         i, done_q[i].cyc - done_q[i-1].cyc);
            end
        end
        step(2);
    endtask

    task automatic test_timeout();
        int issue;
        // pready arrives in the last allowed ACCESS cycle: success.
        clear_logs();
        slave_wait = int'(TO) - 1;
        slave_rd   = 8'h5A;
        req0_write = 1'b0; req0_addr = 8'h10; req0_valid = 1'b1;
        issue = cyc;
        wait_done(1, 60);
        req0_valid = 1'b0;
        n_checks++;
        if (done_q.size() !== 1) begin
            n_fail++;
            $display("FAIL edge_complete: got %0d completions, required 1", done_q.size());
            return;
        end
        n_checks++;
        if (done_q[0].err !== 1'b0 || done_q[0].rdata !== 8'h5A || done_q[0].cyc !== issue + int'(TO) + 2) begin
            n_fail++;
            $display("FAIL edge_result: got err %b rdata %h at +%0d, required 0 5A at +%0d",
                     done_q[0].err, done_q[0].rdata, done_q[0].cyc - issue, TO + 2);
        end
        step(2);
        // pready never arrives: abort after TO ACCESS cycles.
        clear_logs();
        slave_wait = 255;
        req0_valid = 1'b1;
        issue = cyc;
        wait_done(1, 60);
        n_checks++;
        if (done_q.size() !== 1) begin
            n_fail++;
            $display("FAIL timeout_complete: got %0d completions, required 1", done_q.size());
            req0_valid = 1'b0;
            return;
        end
        n_checks++;
        if (psel !== 1'b0 || penable !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_psel: got psel %b penable %b, required 0 0", psel, penable);
        end
        req0_valid = 1'b0;
        n_checks++;
        if (done_q[0].err !== 1'b1 || done_q[0].rdata !== 8'h00 || done_q[0].cyc !== issue + int'(TO) + 2) begin
            n_fail++;
            $display("FAIL timeout_result: got err %b rdata %h at +%0d, required 1 00 at +%0d",
                     done_q[0].err, done_q[0].rdata, done_q[0].cyc - issue, TO + 2);
        end
        n_checks++;
        if (pen_cnt !== int'(TO)) begin
            n_fail++;
            $display("FAIL timeout_access: got %0d ACCESS cycles, required %0d", pen_cnt, TO);
        end
        step(2);
    endtask

    task automatic test_reset_mid();
        clear_logs();
        slave_wait = 255;
        req1_write = 1'b1; req1_addr = 8'h33; req1_wdata = 8'h77; req1_valid = 1'b1;
        step(3);
        n_checks++;
        if (penable !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_access: got penable %b, required 1", penable);
        end
        preset = 1'b1;
        step(1);
        n_checks++;
        if ({psel, penable, pwrite, paddr, pwdata} !== 19'h0) begin
            n_fail++;
            $display("FAIL midreset_bus: got %h, required 0", {psel, penable, pwrite, paddr, pwdata});
        end
        n_checks++;
        if ({req0_ready, req0_err, req0_rdata, req1_ready, req1_err, req1_rdata} !== 20'h0) begin
            n_fail++;
            $display("FAIL midreset_req: got %h, required 0",
                     {req0_ready, req0_err, req0_rdata, req1_ready, req1_err, req1_rdata});
        end
        preset     = 1'b0;
        req1_valid = 1'b0;
        step(20);
        n_checks++;
        if (rdy0_cnt !== 0 || rdy1_cnt !== 0) begin
            n_fail++;
            $display("FAIL midreset_nopulse: got ready0 %0d ready1 %0d, required 0 0", rdy0_cnt, rdy1_cnt);
        end
        clear_logs();
        slave_wait = 0;
        req0_write = 1'b0; req0_addr = 8'h01;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        wait_done(1, 40);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n_checks++;
        if (done_q.size() !== 1 || done_q[0].id !== 0) begin
            n_fail++;
            $display("FAIL midreset_tie: got %0d completions first id %0d, required 1 id 0",
                     done_q.size(), (done_q.size() > 0) ? done_q[0].id : -1);
        end
        step(2);
    endtask

    task automatic test_random();
        int     rem0, rem1, k, model_last, exp_id, exp_cyc;
        logic   exp_err;
        logic [7:0] exp_rd, exp_wd;
        done_t  d;
        grant_t g;
        tx_t    t;
        do_reset();
        slave_random = 1'b1;
        model_last   = 1;
        rem0 = 25;
        rem1 = 25;
        k    = 0;
        while ((rem0 > 0 || rem1 > 0 || req0_valid || req1_valid) && k < 5000) begin
            step(1);
            k++;
            while (done_q.size() > 0) begin
                d = done_q.pop_front();
                if (d.id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
                n_checks++;
                if (slog.size() == 0 || (d.id == 0 && iss0.size() == 0) || (d.id == 1 && iss1.size() == 0)) begin
                    n_fail++;
                    $display("FAIL rand_orphan: completion for req%0d with no matching grant", d.id);
                    continue;
                end
                g = slog.pop_front();
                t = (d.id == 0) ? iss0.pop_front() : iss1.pop_front();
                // Rule-level arbitration: a tie goes to whoever was not served last.
                if (g.v0 && g.v1) exp_id = 1 - model_last;
                else              exp_id = g.v0 ? 0 : 1;
                model_last = exp_id;
                if (d.id !== exp_id) begin
                    n_fail++;
                    $display("FAIL rand_grant: got req%0d, required req%0d", d.id, exp_id);
                end
                exp_wd = t.wr ? t.wd : 8'h00;
                n_checks++;
                if (g.addr !== t.addr || g.wr !== t.wr || g.wd !== exp_wd) begin
                    n_fail++;
                    $display("FAIL rand_bus: got addr %h write %b wdata %h, required %h %b %h",
                             g.addr, g.wr, g.wd, t.addr, t.wr, exp_wd);
                end
                exp_err = (g.wait_n >= int'(TO));
                exp_rd  = (exp_err || t.wr) ? 8'h00 : g.rd;
                exp_cyc = g.setup_cyc + (exp_err ? int'(TO) : g.wait_n + 1) + 1;
                n_checks++;
                if (d.err !== exp_err || d.rdata !== exp_rd) begin
                    n_fail++;
                    $display("FAIL rand_result: got err %b rdata %h, required %b %h (wait %0d)",
                             d.err, d.rdata, exp_err, exp_rd, g.wait_n);
                end
                n_checks++;
                if (d.cyc !== exp_cyc) begin
                    n_fail++;
                    $display("FAIL rand_latency: got done at %0d, required %0d", d.cyc, exp_cyc);
                end
            end
            if (!req0_valid && rem0 > 0 && $urandom_range(0, 2) == 0) begin
                t.wr = 1'($urandom_range(0, 1)); t.addr = 8'($urandom_range(0, 255)); t.wd = 8'($urandom_range(0, 255));
                req0_write = t.wr; req0_addr = t.addr; req0_wdata = t.wd;
                iss0.push_back(t);
                req0_valid = 1'b1;
                rem0--;
            end
            if (!req1_valid && rem1 > 0 && $urandom_range(0, 2) == 0) begin
                t.wr = 1'($urandom_range(0, 1)); t.addr = 8'($urandom_range(0, 255)); t.wd = 8'($urandom_range(0, 255));
                req1_write = t.wr; req1_addr = t.addr; req1_wdata = t.wd;
                iss1.push_back(t);
                req1_valid = 1'b1;
                rem1--;
            end
        end
        n_checks++;
        if (k >= 5000 || iss0.size() != 0 || iss1.size() != 0) begin
            n_fail++;
            $display("FAIL rand_drain: got %0d/%0d outstanding after %0d cycles, required 0/0",
                     iss0.size(), iss1.size(), k);
        end
        slave_random = 1'b0;
        req0_valid   = 1'b0;
        req1_valid   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_wait();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
